alu_bist: RTL and testbench

- Synthesizable built-in self-test controller for the 16-bit CPU ALU.
- Drives the ALU operand/opcode/shift inputs and reads back result and N/Z/V. Compares each response against an internal golden model and latches the first mismatch.
- Sits beside the ALU in the CPU datapath and is muxed onto the ALU inputs while busy. Gives silicon/FPGA self-check of all eight ALU operations.

---
 rtl/cpu_pkg.sv | 56 +++++
 rtl/alu_golden.sv | 47 ++++
 rtl/alu_bist.sv | 166 ++++++++++++++++
 tb/tb_alu_bist.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU ALU definitions: opcodes, BIST phase sequence and the saturating-add
// reference used by the golden model.
package cpu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_NOT = 3'b011;
  localparam logic [2:0] ALU_ADD = 3'b100;
  localparam logic [2:0] ALU_LSL = 3'b101;
  localparam logic [2:0] ALU_SR  = 3'b110;
  localparam logic [2:0] ALU_ROT = 3'b111;

  typedef enum logic [3:0] {
    PH_AND = 4'd0, PH_OR  = 4'd1, PH_XOR = 4'd2, PH_NOT = 4'd3, PH_ADD = 4'd4,
    PH_LSL = 4'd5, PH_LSR = 4'd6, PH_ASR = 4'd7, PH_ROL = 4'd8, PH_ROR = 4'd9
  } phase_e;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  typedef struct packed {
    logic [2:0] op;
    logic       x;
  } alu_ctrl_t;

  function automatic alu_ctrl_t phase_ctrl(input phase_e ph);
    alu_ctrl_t c;
    c = '{op: ALU_AND, x: 1'b0};
    case (ph)
      PH_AND: c.op = ALU_AND;
      PH_OR:  c.op = ALU_OR;
      PH_XOR: c.op = ALU_XOR;
      PH_NOT: c.op = ALU_NOT;
      PH_ADD: c.op = ALU_ADD;
      PH_LSL: c.op = ALU_LSL;
      PH_LSR: c.op = ALU_SR;
      PH_ASR: begin c.op = ALU_SR;  c.x = 1'b1; end
      PH_ROL: c.op = ALU_ROT;
      PH_ROR: begin c.op = ALU_ROT; c.x = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  // Returns {overflow, result}; overflow clamps to the signed extreme.
  function automatic logic [16:0] sat_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] s;
    logic [16:0] r;
    s = a + b;
    if (!a[15] && !b[15] && s[15])      r = {1'b1, 16'h7FFF};
    else if (a[15] && b[15] && !s[15])  r = {1'b1, 16'h8000};
    else                                r = {1'b0, s};
    return r;
  endfunction

endpackage

// File: rtl/alu_golden.sv
// Combinational reference model of the 16-bit CPU ALU (result plus N/Z/V).
module alu_golden
  import cpu_pkg::*;
(
  input  logic [15:0] i_op0,
  input  logic [15:0] i_op1,
  input  logic [2:0]  i_alu_op,
  input  logic [3:0]  i_shamt,
  input  logic        i_x,
  output logic [15:0] o_gold,
  output logic        o_n,
  output logic        o_z,
  output logic        o_v
);

  logic [15:0] w_gold;
  logic        w_v;

  always_comb begin
    w_gold = '0;
    w_v    = 1'b0;
    case (i_alu_op)
      ALU_AND: w_gold = i_op0 & i_op1;
      ALU_OR:  w_gold = i_op0 | i_op1;
      ALU_XOR: w_gold = i_op0 ^ i_op1;
      ALU_NOT: w_gold = ~i_op0;
      ALU_ADD: {w_v, w_gold} = sat_add(i_op0, i_op1);
      ALU_LSL: w_gold = i_op0 << i_shamt;
      // Separate branches keep the arithmetic shift in a signed context.
      ALU_SR: begin
        if (i_x) w_gold = $signed(i_op0) >>> i_shamt;
        else     w_gold = i_op0 >> i_shamt;
      end
      ALU_ROT: begin
        if (i_x) w_gold = {i_op0[0], i_op0[15:1]};
        else     w_gold = {i_op0[14:0], i_op0[15]};
      end
      default: ;
    endcase
  end

  assign o_gold = w_gold;
  assign o_n    = w_gold[15];
  assign o_z    = (w_gold == 16'h0000);
  assign o_v    = w_v;

endmodule

// File: rtl/alu_bist.sv
// ALU built-in self-test controller: sweeps ten operation phases, checks every
// response against alu_golden and latches the first mismatch.
module alu_bist
  import cpu_pkg::*;
#(
  parameter int VEC_PER_PHASE = 1000,
  parameter int ADD_VECS      = 65536,
  parameter bit CHECK_FLAGS   = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [15:0] op0,
  output logic [15:0] op1,
  output logic [2:0]  ALU_op,
  output logic [3:0]  shamt,
  output logic        X,
  input  logic [15:0] result,
  input  logic        N,
  input  logic        Z,
  input  logic        V,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_phase,
  output logic [16:0] fail_vec,
  output logic [15:0] fail_result,
  output logic [15:0] fail_expected
);

  localparam logic [16:0] VEC_LAST = 17'(VEC_PER_PHASE - 1);
  localparam logic [16:0] ADD_LAST = 17'(ADD_VECS - 1);

  state_e      r_state, w_next;
  phase_e      r_phase, w_next_phase;
  alu_ctrl_t   w_next_ctrl;
  logic [16:0] r_vec;
  logic [15:0] r_op0, r_op1;
  logic [2:0]  r_alu_op;
  logic [3:0]  r_shamt;
  logic        r_x;
  logic        r_done, r_pass;
  logic [3:0]  r_fail_phase;
  logic [16:0] r_fail_vec;
  logic [15:0] r_fail_result, r_fail_expected;

  logic [15:0] w_gold;
  logic        w_gn, w_gz, w_gv;
  logic        w_last_vec, w_flag_bad, w_mismatch;

  alu_golden u_golden (
    .i_op0    (r_op0),
    .i_op1    (r_op1),
    .i_alu_op (r_alu_op),
    .i_shamt  (r_shamt),
    .i_x      (r_x),
    .o_gold   (w_gold),
    .o_n      (w_gn),
    .o_z      (w_gz),
    .o_v      (w_gv)
  );

  always_comb begin
    w_last_vec   = (r_vec == ((r_phase == PH_ADD) ? ADD_LAST : VEC_LAST));
    w_flag_bad   = CHECK_FLAGS && (r_phase == PH_ADD) && ({N, Z, V} !== {w_gn, w_gz, w_gv});
    w_mismatch   = (r_state == S_RUN) && ((result !== w_gold) || w_flag_bad);
    w_next_phase = phase_e'(r_phase + 4'd1);
    w_next_ctrl  = phase_ctrl(w_next_phase);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next = S_RUN;
      S_RUN: if (w_mismatch || (w_last_vec && r_phase == PH_ROR)) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase         <= PH_AND;
      r_vec           <= '0;
      r_op0           <= '0;
      r_op1           <= '0;
      r_alu_op        <= '0;
      r_shamt         <= '0;
      r_x             <= 1'b0;
      r_done          <= 1'b0;
      r_pass          <= 1'b0;
      r_fail_phase    <= '0;
      r_fail_vec      <= '0;
      r_fail_result   <= '0;
      r_fail_expected <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_phase         <= PH_AND;
            r_vec           <= '0;
            r_op0           <= '0;
            r_op1           <= '0;
            r_alu_op        <= phase_ctrl(PH_AND).op;
            r_x             <= phase_ctrl(PH_AND).x;
            r_shamt         <= '0;
            r_done          <= 1'b0;
            r_pass          <= 1'b0;
            r_fail_phase    <= '0;
            r_fail_vec      <= '0;
            r_fail_result   <= '0;
            r_fail_expected <= '0;
          end
        end
        S_RUN: begin
          if (w_mismatch) begin
            r_done          <= 1'b1;
            r_pass          <= 1'b0;
            r_fail_phase    <= r_phase;
            r_fail_vec      <= r_vec;
            r_fail_result   <= result;
            r_fail_expected <= w_gold;
          end else if (w_last_vec) begin
            if (r_phase == PH_ROR) begin
              r_done <= 1'b1;
              r_pass <= 1'b1;
            end else begin
              r_phase  <= w_next_phase;
              r_vec    <= '0;
              r_op0    <= '0;
              r_op1    <= '0;
              r_shamt  <= '0;
              r_alu_op <= w_next_ctrl.op;
              r_x      <= w_next_ctrl.x;
            end
          end else begin
            r_vec <= r_vec + 17'd1;
            r_op0 <= r_op0 + 16'd1;
            r_op1 <= r_op1 + 16'd2;
            // Only the shift phases sweep the shift amount.
            if (r_phase inside {PH_LSL, PH_LSR, PH_ASR}) r_shamt <= r_shamt + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign op0           = r_op0;
  assign op1           = r_op1;
  assign ALU_op        = r_alu_op;
  assign shamt         = r_shamt;
  assign X             = r_x;
  assign busy          = (r_state == S_RUN);
  assign done          = r_done;
  assign pass          = r_pass;
  assign fail_phase    = r_fail_phase;
  assign fail_vec      = r_fail_vec;
  assign fail_result   = r_fail_result;
  assign fail_expected = r_fail_expected;

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three controllers, each driving a behavioural ALU that can
// carry a planted fault; expected run outcomes are queued at start and checked at done.
module tb_alu_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0, passes = 0, fails = 0;

  typedef struct {
    logic [54:0] outv;   // {done, pass, fail_phase, fail_vec, fail_result, fail_expected}
    int          len;    // RUN cycles
  } exp_t;
  exp_t sb_a[$], sb_b[$], sb_c[$];

  // fault: 0 ideal, 1 wrapping ADD, 2 result[0] stuck-at-1, 3 ROT ignores X
  function automatic logic [18:0] alu_model(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] op, input logic [3:0] sh,
                                            input logic x, input int fault);
    logic [15:0] r;
    logic v;
    int s, t;
    r = '0; v = 1'b0;
    case (op)
      3'd0: r = a & b;
      3'd1: r = a | b;
      3'd2: r = a ^ b;
      3'd3: r = ~a;
      3'd4: begin
        s = int'($signed(a)) + int'($signed(b));
        if (fault == 1) begin r = a + b; v = (s > 32767) || (s < -32768); end
        else if (s > 32767)  begin r = 16'h7FFF; v = 1'b1; end
        else if (s < -32768) begin r = 16'h8000; v = 1'b1; end
        else r = s[15:0];
      end
      3'd5: r = a << sh;
      3'd6: begin
        if (x) begin t = int'($signed(a)); t = t >>> sh; r = t[15:0]; end
        else r = a >> sh;
      end
      default: begin
        if (x && fault != 3) r = {a[0], a[15:1]};
        else                 r = {a[14:0], a[15]};
      end
    endcase
    if (fault == 2) r[0] = 1'b1;
    return {r[15], r == 16'h0000, v, r};
  endfunction

  // Stimulus expected on RUN cycle c: {op0, op1, ALU_op, shamt, X}
  function automatic logic [39:0] stim_exp(input int c, input int vpp, input int addv);
    int ph, v, len;
    logic [2:0] op;
    logic x;
    logic [3:0] sh;
    ph = 0; v = c;
    while (ph < 9) begin
      len = (ph == 4) ? addv : vpp;
      if (v < len) break;
      v -= len;
      ph++;
    end
    op = (ph < 5) ? 3'(ph) : (ph == 5) ? 3'd5 : (ph < 8) ? 3'd6 : 3'd7;
    x  = (ph == 7) || (ph == 9);
    sh = (ph >= 5 && ph <= 7) ? 4'(v) : 4'd0;
    return {16'(v), 16'(2 * v), op, sh, x};
  endfunction

  function automatic logic [54:0] mk(input bit ok, input int ph, input int vec,
                                     input logic [15:0] r, input logic [15:0] e);
    return {1'b1, ok, 4'(ph), 17'(vec), r, e};
  endfunction

  // ---------------- DUT A: VEC_PER_PHASE=4, ADD_VECS=8 ----------------
  logic        start_a = 1'b0;
  logic [15:0] op0_a, op1_a, res_a, fres_a, fexp_a;
  logic [2:0]  aluop_a;
  logic [3:0]  shamt_a, fph_a;
  logic [16:0] fvec_a;
  logic        x_a, N_a, Z_a, V_a, busy_a, done_a, pass_a;
  int          fault_a = 0, cyc_a = 0, stim_bad_a = 0;

  always_comb {N_a, Z_a, V_a, res_a} = alu_model(op0_a, op1_a, aluop_a, shamt_a, x_a, fault_a);

  alu_bist #(.VEC_PER_PHASE(4), .ADD_VECS(8), .CHECK_FLAGS(1)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op0(op0_a), .op1(op1_a), .ALU_op(aluop_a),
    .shamt(shamt_a), .X(x_a), .result(res_a), .N(N_a), .Z(Z_a), .V(V_a), .busy(busy_a),
    .done(done_a), .pass(pass_a), .fail_phase(fph_a), .fail_vec(fvec_a),
    .fail_result(fres_a), .fail_expected(fexp_a));

  always @(negedge clk) begin
    if (busy_a) begin
      if ({op0_a, op1_a, aluop_a, shamt_a, x_a} !== stim_exp(cyc_a, 4, 8)) stim_bad_a++;
      cyc_a++;
    end
  end

  // ---------------- DUT B: default parameters ----------------
  logic        start_b = 1'b0;
  logic [15:0] op0_b, op1_b, res_b, fres_b, fexp_b;
  logic [2:0]  aluop_b;
  logic [3:0]  shamt_b, fph_b;
  logic [16:0] fvec_b;
  logic        x_b, N_b, Z_b, V_b, busy_b, done_b, pass_b;
  int          fault_b = 0, cyc_b = 0;

  always_comb {N_b, Z_b, V_b, res_b} = alu_model(op0_b, op1_b, aluop_b, shamt_b, x_b, fault_b);

  alu_bist dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op0(op0_b), .op1(op1_b), .ALU_op(aluop_b),
    .shamt(shamt_b), .X(x_b), .result(res_b), .N(N_b), .Z(Z_b), .V(V_b), .busy(busy_b),
    .done(done_b), .pass(pass_b), .fail_phase(fph_b), .fail_vec(fvec_b),
    .fail_result(fres_b), .fail_expected(fexp_b));

  always @(negedge clk) if (busy_b) cyc_b++;

  // ---------------- DUT C: long ADD phase reaching both saturation limits ----------------
  logic        start_c = 1'b0;
  logic [15:0] op0_c, op1_c, res_c, fres_c, fexp_c;
  logic [2:0]  aluop_c;
  logic [3:0]  shamt_c, fph_c;
  logic [16:0] fvec_c;
  logic        x_c, N_c, Z_c, V_c, busy_c, done_c, pass_c;
  int          cyc_c = 0;

  always_comb {N_c, Z_c, V_c, res_c} = alu_model(op0_c, op1_c, aluop_c, shamt_c, x_c, 0);

  alu_bist #(.VEC_PER_PHASE(2), .ADD_VECS(49200), .CHECK_FLAGS(1)) dut_c (
    .clk(clk), .rst(rst), .start(start_c), .op0(op0_c), .op1(op1_c), .ALU_op(aluop_c),
    .shamt(shamt_c), .X(x_c), .result(res_c), .N(N_c), .Z(Z_c), .V(V_c), .busy(busy_c),
    .done(done_c), .pass(pass_c), .fail_phase(fph_c), .fail_vec(fvec_c),
    .fail_result(fres_c), .fail_expected(fexp_c));

  always @(negedge clk) if (busy_c) cyc_c++;

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic pulse_a();
    @(posedge clk); #1 start_a = 1'b1; cyc_a = 0; stim_bad_a = 0;
    @(posedge clk); #1 start_a = 1'b0;
  endtask
  task automatic pulse_b();
    @(posedge clk); #1 start_b = 1'b1; cyc_b = 0;
    @(posedge clk); #1 start_b = 1'b0;
  endtask
  task automatic pulse_c();
    @(posedge clk); #1 start_c = 1'b1; cyc_c = 0;
    @(posedge clk); #1 start_c = 1'b0;
  endtask
  task automatic wait_done_a(input int bound);
    for (int i = 0; i < bound; i++) begin @(negedge clk); if (done_a) break; end
  endtask
  task automatic wait_done_b(input int bound);
    for (int i = 0; i < bound; i++) begin @(negedge clk); if (done_b) break; end
  endtask
  task automatic wait_done_c(input int bound);
    for (int i = 0; i < bound; i++) begin @(negedge clk); if (done_c) break; end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [95:0] o;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    o = {op0_a, op1_a, aluop_a, shamt_a, x_a, busy_a, done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== 96'h0) begin fails++; $display("FAIL reset_a: got %h want 0", o); end else passes++;
    o = {op0_b, op1_b, aluop_b, shamt_b, x_b, busy_b, done_b, pass_b, fph_b, fvec_b, fres_b, fexp_b};
    checks++; if (o !== 96'h0) begin fails++; $display("FAIL reset_b: got %h want 0", o); end else passes++;
    o = {op0_c, op1_c, aluop_c, shamt_c, x_c, busy_c, done_c, pass_c, fph_c, fvec_c, fres_c, fexp_c};
    checks++; if (o !== 96'h0) begin fails++; $display("FAIL reset_c: got %h want 0", o); end else passes++;
  endtask

  task automatic test_pass_small();
    exp_t e;
    logic [54:0] o;
    sb_a.push_back('{outv: mk(1, 0, 0, 16'h0, 16'h0), len: 44});
    pulse_a();
    wait_done_a(200);
    e = sb_a.pop_front();
    o = {done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL pass_small_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_a !== e.len) begin fails++; $display("FAIL pass_small_len: got %0d want %0d", cyc_a, e.len); end else passes++;
    checks++; if (stim_bad_a !== 0) begin fails++; $display("FAIL pass_small_stim: %0d bad cycles want 0", stim_bad_a); end else passes++;
  endtask

  task automatic test_stuck();
    exp_t e;
    logic [54:0] o;
    fault_a = 2;
    sb_a.push_back('{outv: mk(0, 0, 0, 16'h0001, 16'h0000), len: 1});
    pulse_a();
    wait_done_a(200);
    e = sb_a.pop_front();
    o = {done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL stuck_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_a !== e.len) begin fails++; $display("FAIL stuck_len: got %0d want %0d", cyc_a, e.len); end else passes++;
    fault_a = 0;
  endtask

  task automatic test_rot();
    exp_t e;
    logic [54:0] o;
    logic [39:0] s;
    fault_a = 3;
    sb_a.push_back('{outv: mk(0, 9, 1, 16'h0002, 16'h8000), len: 42});
    pulse_a();
    wait_done_a(200);
    e = sb_a.pop_front();
    o = {done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL rot_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_a !== e.len) begin fails++; $display("FAIL rot_len: got %0d want %0d", cyc_a, e.len); end else passes++;
    // Stimulus holds the failing vector while in DONE
    s = {op0_a, op1_a, aluop_a, shamt_a, x_a};
    checks++; if (s !== {16'h0001, 16'h0002, 3'd7, 4'd0, 1'b1}) begin
      fails++; $display("FAIL rot_hold: got %h want %h", s, {16'h0001, 16'h0002, 3'd7, 4'd0, 1'b1});
    end else passes++;
    fault_a = 0;
  endtask

  task automatic test_rst_mid();
    exp_t e;
    logic [54:0] o;
    logic [95:0] z;
    pulse_a();
    repeat (18) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    z = {op0_a, op1_a, aluop_a, shamt_a, x_a, busy_a, done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (z !== 96'h0) begin fails++; $display("FAIL rst_mid_zero: got %h want 0", z); end else passes++;
    sb_a.push_back('{outv: mk(1, 0, 0, 16'h0, 16'h0), len: 44});
    pulse_a();
    wait_done_a(200);
    e = sb_a.pop_front();
    o = {done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL rst_rerun_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_a !== e.len) begin fails++; $display("FAIL rst_rerun_len: got %0d want %0d", cyc_a, e.len); end else passes++;
    checks++; if (stim_bad_a !== 0) begin fails++; $display("FAIL rst_rerun_stim: %0d bad cycles want 0", stim_bad_a); end else passes++;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [54:0] o;
    logic [2:0] f;
    // A is in DONE with pass=1: start must clear done/pass and re-enter RUN
    sb_a.push_back('{outv: mk(1, 0, 0, 16'h0, 16'h0), len: 44});
    pulse_a();
    @(negedge clk);
    f = {done_a, pass_a, busy_a};
    checks++; if (f !== 3'b001) begin fails++; $display("FAIL restart_clear: got %b want 001", f); end else passes++;
    repeat (10) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk);
    #1 start_a = 1'b0;
    wait_done_a(200);
    e = sb_a.pop_front();
    o = {done_a, pass_a, fph_a, fvec_a, fres_a, fexp_a};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL b2b_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_a !== e.len) begin fails++; $display("FAIL b2b_len: got %0d want %0d", cyc_a, e.len); end else passes++;
    checks++; if (stim_bad_a !== 0) begin fails++; $display("FAIL b2b_stim: %0d bad cycles want 0", stim_bad_a); end else passes++;
  endtask

  task automatic test_saturate();
    exp_t e;
    logic [54:0] o;
    fault_b = 1;
    sb_b.push_back('{outv: mk(0, 4, 10923, 16'h8001, 16'h7FFF), len: 4000 + 10924});
    sb_c.push_back('{outv: mk(1, 0, 0, 16'h0, 16'h0), len: 18 + 49200});
    fork
      begin pulse_b(); wait_done_b(20000); end
      begin pulse_c(); wait_done_c(60000); end
    join
    e = sb_b.pop_front();
    o = {done_b, pass_b, fph_b, fvec_b, fres_b, fexp_b};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL nonsat_add_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_b !== e.len) begin fails++; $display("FAIL nonsat_add_len: got %0d want %0d", cyc_b, e.len); end else passes++;
    e = sb_c.pop_front();
    o = {done_c, pass_c, fph_c, fvec_c, fres_c, fexp_c};
    checks++; if (o !== e.outv) begin fails++; $display("FAIL sat_full_result: got %h want %h", o, e.outv); end else passes++;
    checks++; if (cyc_c !== e.len) begin fails++; $display("FAIL sat_full_len: got %0d want %0d", cyc_c, e.len); end else passes++;
    fault_b = 0;
  endtask

  initial begin
    test_reset();
    test_pass_small();
    test_stuck();
    test_rot();
    test_rst_mid();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
